ram512_dma: RTL and testbench

Block-transfer initiator that drives the address/data/load side of a RAM512 memory, copying `len` consecutive words from a source range to a destination range without CPU involvement. Sits between the control logic, which issues `start` with `src`/`dst`/`len` and waits for `done`, and a single RAM512 instance, which this block owns exclusively while `busy`. RAM512 is the responder; this block is the initiator on the same `in`/`load`/`address`/`out` interface.

---
 rtl/ram512_dma_pkg.sv | 16 +
 rtl/ram512_dma_ctr.sv | 53 +++++
 rtl/ram512_dma.sv | 154 +++++++++++++++
 tb/tb_ram512_dma.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram512_dma_pkg.sv
// Shared types and defaults for the RAM512 block-copy initiator.
package ram512_dma_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;
    localparam int MAX_LEN    = 512;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FIN  = 3'd3,
        FILL = 3'd4
    } dma_state_t;

endpackage

// File: rtl/ram512_dma_ctr.sv
// Source/destination pointers with wrap, remaining-word counter and last-word flag.
module ram512_dma_ctr #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [ADDR_W:0]   cnt_i,
    output logic [ADDR_W-1:0] src_ptr_o,
    output logic [ADDR_W-1:0] dst_ptr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // Pointer increments rely on natural ADDR_W-bit overflow for the wrap to 0.
    always_comb begin
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            src_ptr_d = src_i;
            dst_ptr_d = dst_i;
            cnt_d     = cnt_i;
        end else if (step_i) begin
            src_ptr_d = src_ptr_q + 1'b1;
            dst_ptr_d = dst_ptr_q + 1'b1;
            cnt_d     = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
        end else begin
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign src_ptr_o = src_ptr_q;
    assign dst_ptr_o = dst_ptr_q;
    assign last_o    = (cnt_q == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/ram512_dma.sv
// RAM512 block-copy initiator: forward word-by-word copy src->dst, two cycles per word.
// Optional constant-fill mode is enabled by defining RAM512_DMA_FILL_EN.
module ram512_dma
    import ram512_dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
`ifdef RAM512_DMA_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    dma_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic              last;
    logic              accept;
    logic              step;
    logic              fill_sel;

`ifdef RAM512_DMA_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_value_q;

    assign fill_sel = fill;
`else
    assign fill_sel = 1'b0;
`endif

    assign accept      = (state_q == IDLE) && start;
    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
    assign step        = (state_q == WR) || (state_q == FILL);

    ram512_dma_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .step_i    (step),
        .src_i     (src),
        .dst_i     (dst),
        .cnt_i     (len_clamped),
        .src_ptr_o (src_ptr),
        .dst_ptr_o (dst_ptr),
        .last_o    (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_clamped == '0) begin
                        state_d = FIN;
                    end else if (fill_sel) begin
                        state_d = FILL;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:  state_d = WR;
            WR:  state_d = last ? FIN : RD;
`ifdef RAM512_DMA_FILL_EN
            FILL: state_d = last ? FIN : FILL;
`endif
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address and write data fall back to the held copies so they keep their last value when idle.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == FIN);
        mem_load    = 1'b0;
        mem_address = addr_q;
        mem_in      = din_q;
        case (state_q)
            RD: begin
                mem_address = src_ptr;
            end
            WR: begin
                mem_address = dst_ptr;
                mem_in      = data_q;
                mem_load    = 1'b1;
            end
`ifdef RAM512_DMA_FILL_EN
            FILL: begin
                mem_address = dst_ptr;
                mem_in      = fill_value_q;
                mem_load    = 1'b1;
            end
`endif
            default: begin
                mem_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= mem_address;
            din_q  <= mem_in;
            if (state_q == RD) begin
                data_q <= mem_out;
            end
        end
    end

`ifdef RAM512_DMA_FILL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q       <= 1'b0;
            fill_value_q <= '0;
        end else if (accept) begin
            fill_q       <= fill;
            fill_value_q <= fill_value;
        end
    end
`endif

endmodule

// File: tb/tb_ram512_dma.sv
// Directed bench for ram512_dma with a behavioural RAM512 behind it (combinational read, clocked write).
module tb_ram512_dma;
    import ram512_dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  src = '0;
    logic [8:0]  dst = '0;
    logic [9:0]  len = '0;
`ifdef RAM512_DMA_FILL_EN
    logic        fill = 1'b0;
    logic [15:0] fill_value = '0;
`endif
    logic        busy, done, mem_load;
    logic [8:0]  mem_address;
    logic [15:0] mem_in, mem_out;

    logic [15:0] ram   [512];
    logic [15:0] exp_m [512];
    logic        tb_init = 1'b0;
    logic        tb_we = 1'b0;
    logic [8:0]  tb_addr = '0;
    logic [15:0] tb_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_out = ram[mem_address];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 512; i++) ram[i] <= 16'h1000 + 16'(i);
        end else if (tb_we) begin
            ram[tb_addr] <= tb_data;
        end else if (mem_load) begin
            ram[mem_address] <= mem_in;
        end
    end

    ram512_dma dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src         (src),
        .dst         (dst),
        .len         (len),
`ifdef RAM512_DMA_FILL_EN
        .fill        (fill),
        .fill_value  (fill_value),
`endif
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_load    (mem_load),
        .mem_out     (mem_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < 512; i++) begin
            if (ram[i] !== exp_m[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s bad_words=%0d first_addr=%0d actual=0x%0h required=0x%0h",
                     name, bad, first, ram[first], exp_m[first]);
        end
    endtask

    task automatic init_ram();
        @(negedge clk);
        tb_init = 1'b1;
        @(posedge clk);
        #1;
        tb_init = 1'b0;
        for (int i = 0; i < 512; i++) exp_m[i] = 16'h1000 + 16'(i);
    endtask

    task automatic poke(input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
        exp_m[a] = d;
    endtask

    task automatic model_copy(input logic [8:0] s, input logic [8:0] d, input int n);
        for (int k = 0; k < n; k++) exp_m[9'(d + 9'(k))] = exp_m[9'(s + 9'(k))];
    endtask

    // Cycle c is the interval after edge c, where edge 0 accepts start; sampled on the falling edge.
    task automatic run_xfer(input logic [8:0] s, input logic [8:0] d, input logic [9:0] l,
                            input bit extra, output int done_cyc, output int busy_cyc, output int loads);
        @(negedge clk);
        src = s;
        dst = d;
        len = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src = s + 9'd7;
        dst = d + 9'd33;
        len = 10'd3;
        done_cyc = -1;
        busy_cyc = 0;
        loads = 0;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (mem_load) loads++;
            if (done) begin
                done_cyc = c;
                break;
            end
            start = extra && (c == 3 || c == 5);
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [8:0] s;
        logic [8:0] d;
        logic [9:0] l;
        int         exp_done;
        int         exp_loads;
        bit         extra;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int done_cyc, busy_cyc, loads, n, pulses;

        vecs[0] = '{s: 9'd10,  d: 9'd100, l: 10'd4,   exp_done: 9,    exp_loads: 4,   extra: 1'b0};
        vecs[1] = '{s: 9'd50,  d: 9'd60,  l: 10'd0,   exp_done: 1,    exp_loads: 0,   extra: 1'b0};
        vecs[2] = '{s: 9'd510, d: 9'd0,   l: 10'd4,   exp_done: 9,    exp_loads: 4,   extra: 1'b0};
        vecs[3] = '{s: 9'd20,  d: 9'd22,  l: 10'd5,   exp_done: 11,   exp_loads: 5,   extra: 1'b0};
        vecs[4] = '{s: 9'd300, d: 9'd50,  l: 10'd1,   exp_done: 3,    exp_loads: 1,   extra: 1'b0};
        vecs[5] = '{s: 9'd40,  d: 9'd140, l: 10'd4,   exp_done: 9,    exp_loads: 4,   extra: 1'b1};
        vecs[6] = '{s: 9'd0,   d: 9'd256, l: 10'd600, exp_done: 1025, exp_loads: 512, extra: 1'b0};
        vecs[7] = '{s: 9'd5,   d: 9'd9,   l: 10'd512, exp_done: 1025, exp_loads: 512, extra: 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_load", mem_load, 0);
        check("reset_addr", mem_address, 0);
        check("reset_din", mem_in, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            init_ram();
            if (i == 0) begin
                for (int k = 0; k < 4; k++) poke(9'd10 + 9'(k), 16'h00A0 + 16'(k));
            end
            run_xfer(vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].extra, done_cyc, busy_cyc, loads);
            n = (int'(vecs[i].l) > MAX_LEN) ? MAX_LEN : int'(vecs[i].l);
            model_copy(vecs[i].s, vecs[i].d, n);
            $display("vec %0d src=%0d dst=%0d len=%0d done_cycle=%0d busy_cycles=%0d loads=%0d",
                     i, vecs[i].s, vecs[i].d, vecs[i].l, done_cyc, busy_cyc, loads);
            check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
            check($sformatf("v%0d_busy_cycles", i), busy_cyc, vecs[i].exp_done);
            check($sformatf("v%0d_loads", i), loads, vecs[i].exp_loads);
            check_mem($sformatf("v%0d_mem", i));
            if (i == 0) begin
                check("v0_ram100", ram[100], 16'h00A0);
                check("v0_ram103", ram[103], 16'h00A3);
            end
            if (i == 2) begin
                check("v2_ram0", ram[0], 16'h11FE);
                check("v2_ram1", ram[1], 16'h11FF);
                check("v2_ram2", ram[2], 16'h11FE);
                check("v2_ram3", ram[3], 16'h11FF);
            end
            @(negedge clk);
            check($sformatf("v%0d_busy_after", i), busy, 0);
            check($sformatf("v%0d_done_after", i), done, 0);
            if (i == 0) begin
                check("v0_hold_addr", mem_address, 103);
                check("v0_hold_din", mem_in, 16'h00A3);
            end
        end

        // Reset during the write of word 2 of an 8-word copy.
        init_ram();
        @(negedge clk);
        src = 9'd200;
        dst = 9'd300;
        len = 10'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_wr2_load_before", mem_load, 1);
        check("rst_wr2_addr_before", mem_address, 302);
        reset = 1'b1;
        #1;
        check("rst_load", mem_load, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", mem_address, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy || mem_load) pulses++;
        end
        $display("reset_mid_transfer src=200 dst=300 len=8 activity_after_reset=%0d", pulses);
        check("rst_no_activity", pulses, 0);
        model_copy(9'd200, 9'd300, 2);
        check("rst_ram300", ram[300], 16'h10C8);
        check("rst_ram302", ram[302], 16'h112E);
        check_mem("rst_mem");

`ifdef RAM512_DMA_FILL_EN
        init_ram();
        fill = 1'b1;
        fill_value = 16'hFFFF;
        run_xfer(9'd3, 9'd508, 10'd6, 1'b0, done_cyc, busy_cyc, loads);
        fill = 1'b0;
        fill_value = 16'h0;
        for (int k = 0; k < 6; k++) exp_m[9'(9'd508 + 9'(k))] = 16'hFFFF;
        $display("fill dst=508 len=6 done_cycle=%0d loads=%0d", done_cyc, loads);
        check("fill_done_cycle", done_cyc, 7);
        check("fill_loads", loads, 6);
        check("fill_ram1", ram[1], 16'hFFFF);
        check_mem("fill_mem");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
